// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes and FSM states.
package muldiv_seq_pkg;

    typedef enum logic [1:0] {
        MD_MUL  = 2'b00,
        MD_MULH = 2'b01,
        MD_DIV  = 2'b10,
        MD_REM  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    localparam int MD_MIN_WIDTH = 4;

    function automatic logic isDivOp(input md_op_e o);
        return (o == MD_DIV) || (o == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring divide step.
// The accumulator is {high, low}; the divide quotient bit is returned separately.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               div_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               qbit_o
);

    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   remShift;
    logic [WIDTH-1:0] diff;

    always_comb begin
        accHi    = acc_i[2*WIDTH-1:WIDTH];
        accLo    = acc_i[WIDTH-1:0];
        sum      = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd_i} : '0);
        remShift = {accHi, accLo[WIDTH-1]};
        // remShift < 2*divisor, so a successful trial subtract always fits in WIDTH bits
        diff     = remShift[WIDTH-1:0] - opnd_i;
        qbit_o   = 1'b0;
        if (div_i) begin
            qbit_o = (remShift >= {1'b0, opnd_i});
            acc_o  = {(qbit_o ? diff : remShift[WIDTH-1:0]), accLo[WIDTH-2:0], 1'b0};
        end else begin
            acc_o  = {sum, accLo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative signed/unsigned multiply/divide unit, one bit per clock, with start/busy/valid handshake.
// Operands are reduced to magnitudes on accept; the sign is re-applied in the FIX state.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic             vout,
    output logic             dz
);

    md_state_e          state_q;
    logic [CNTW-1:0]    cnt_q;
    md_op_e             op_q;
    logic               sgn_q;
    logic               neg_q;
    logic               ovf_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   dout_q;
    logic               vout_q;
    logic               dz_q;
    logic               busy_q;
    logic               valid_q;

    logic [2*WIDTH-1:0] accD;
    logic               qBit;

    md_op_e             opIn;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic               negIn;
    logic               ovfIn;
    logic               divZero;
    logic               accept;

    logic [2*WIDTH-1:0] prodS;
    logic [WIDTH-1:0]   quoS;
    logic [WIDTH-1:0]   remS;
    logic [WIDTH-1:0]   extHi;
    logic [WIDTH-1:0]   fixDout;
    logic               fixVout;

    muldiv_step #(.WIDTH(WIDTH)) uStep (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .div_i  (isDivOp(op_q)),
        .acc_o  (accD),
        .qbit_o (qBit)
    );

    always_comb begin
        opIn    = md_op_e'(op);
        magA    = (sgn && din_a[WIDTH-1]) ? -din_a : din_a;
        magB    = (sgn && din_b[WIDTH-1]) ? -din_b : din_b;
        // REM takes the dividend's sign, everything else the product/quotient sign
        negIn   = sgn && ((opIn == MD_REM) ? din_a[WIDTH-1] : (din_a[WIDTH-1] ^ din_b[WIDTH-1]));
        ovfIn   = sgn && (opIn == MD_DIV) && (din_a == {1'b1, {(WIDTH-1){1'b0}}}) && (din_b == '1);
        divZero = isDivOp(opIn) && (din_b == '0);
        accept  = start && !abort;
    end

    always_comb begin
        prodS   = neg_q ? -acc_q : acc_q;
        quoS    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        remS    = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        extHi   = (sgn_q && prodS[WIDTH-1]) ? '1 : '0;
        fixDout = '0;
        fixVout = 1'b0;
        case (op_q)
            MD_MUL: begin
                fixDout = prodS[WIDTH-1:0];
                fixVout = (prodS[2*WIDTH-1:WIDTH] != extHi);
            end
            MD_MULH: fixDout = prodS[2*WIDTH-1:WIDTH];
            MD_DIV: begin
                fixDout = quoS;
                fixVout = ovf_q;
            end
            default: fixDout = remS;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_MUL;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            vout_q  <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (accept) begin
                        op_q   <= opIn;
                        sgn_q  <= sgn;
                        neg_q  <= negIn;
                        ovf_q  <= ovfIn;
                        opnd_q <= magB;
                        acc_q  <= {{WIDTH{1'b0}}, magA};
                        cnt_q  <= CNTW'(WIDTH);
                        if (divZero) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b1;
                            dout_q  <= (opIn == MD_DIV) ? '1 : din_a;
                            vout_q  <= 1'b0;
                            dz_q    <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= {accD[2*WIDTH-1:1], accD[0] | qBit};
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNTW'(1)) begin
                            state_q <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    busy_q <= 1'b0;
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_DONE;
                        valid_q <= 1'b1;
                        dout_q  <= fixDout;
                        vout_q  <= fixVout;
                        dz_q    <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign dout  = dout_q;
    assign vout  = vout_q;
    assign dz    = dz_q;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Parametrised iterative multiply/divide unit for the 2432 CPU execute stage, and the multi-cycle companion to the single-cycle ALU. It computes WIDTH×WIDTH products (low or high half) and WIDTH/WIDTH quotient or remainder, signed or unsigned, one bit per clock. It uses a start/busy/valid handshake, so the pipeline stalls on `busy` instead of stretching the clock period for wide multiplies.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width; must be at least 4.
- `CNTW`, default $clog2(WIDTH)+1: iteration counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstb`  in  1  asynchronous active-low reset.
- `start`  in  1  request; accepted only when `busy`=0.
- `abort`  in  1  synchronous cancel of an in-flight operation.
- `op`  in  2  operation: 00 MUL (low half), 01 MULH (high half), 10 DIV, 11 REM.
- `sgn`  in  1  1 = operands are two's complement.
- `din_a`  in  WIDTH  multiplicand / dividend.
- `din_b`  in  WIDTH  multiplier / divisor.
- `busy`  out  1  operation in progress.
- `valid`  out  1  one-cycle result strobe.
- `dout`  out  WIDTH  result; held until the next `valid`.
- `vout`  out  1  overflow flag, qualified by `valid`.
- `dz`  out  1  divide-by-zero flag, qualified by `valid`.

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE or DONE with `start`=1:
  - Latch `op` and `sgn`.
  - Latch the magnitudes of `din_a`/`din_b` (absolute value when `sgn`=1 and the MSB is set).
  - Latch the result sign: a^b sign for MUL/MULH/DIV; the dividend sign for REM.
  - Load the counter with WIDTH and go to RUN.
- Divide with `din_b`=0:
  - Go directly to DONE; no RUN or FIX.
  - `dz`=1.
  - DIV returns all ones; REM returns `din_a` unchanged.
- RUN, one step per cycle. Multiply is shift-add into a 2·WIDTH accumulator. Divide is restoring: shift the remainder left, trial-subtract, and shift in the quotient bit. Decrement the counter; when it reaches 0, go to FIX.
- FIX:
  - Negate the magnitude result if the result sign is 1.
  - Select the output half: MUL = low, MULH = high, DIV = quotient, REM = remainder.
  - Register `dout`, `vout`, `dz` and go to DONE.
- DONE: `valid`=1 for exactly one cycle. Return to IDLE, or go to RUN if `start`=1, which gives back-to-back operation.
- `vout` rules:
  - MUL: 1 if the high half is not the sign/zero extension of the low half.
  - DIV signed: 1 for MIN/−1; the quotient wraps to MIN and REM gives 0.
  - MULH, REM, unsigned DIV: 0.
- `start` while `busy`=1 is ignored; no queueing.
- `abort` in RUN or FIX goes to IDLE next cycle. No `valid` is produced and `dout` keeps its previous value. `abort` in IDLE/DONE has no effect, and `abort` wins over a simultaneous `start`.
- Operands are sampled only on the accept edge; later changes to `din_a`/`din_b` have no effect.

## Timing
- Reset values: `busy`=0, `valid`=0, `dout`=0, `vout`=0, `dz`=0; state IDLE; counter 0.
- Normal path: `start` accepted at edge 0.
  - `busy`=1 for cycles 1..WIDTH+1 (RUN for WIDTH cycles, then FIX).
  - `valid`=1 in cycle WIDTH+2 with `busy`=0.
  - Latency is WIDTH+2 cycles; a new `start` in the DONE cycle gives one result every WIDTH+2 cycles.
- Divide-by-zero: `valid`=1 in cycle 1.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous). Release of `rstb` takes effect at the next clock edge.
- `busy` and `valid` are never both 1.

## Structure
- Op encodings go in the shared CPU header alongside the existing opcode defines: `MD_MUL`, `MD_MULH`, `MD_DIV`, `MD_REM`, and the state encodings.
- Sub-module `muldiv_step`: combinational single-iteration datapath. It takes the accumulator, operand and mode, and returns the next accumulator plus the quotient bit. It is reused for both multiply and divide.
- `muldiv_seq` holds the FSM, counter, sign handling and output registers.

## Test plan
- WIDTH=32, MUL unsigned 0x0001_0000 × 0x0001_0000 -> `dout`=0, `vout`=1; MULH -> `dout`=1; `valid` in cycle 34.
- WIDTH=32, signed MUL −7 × 6 -> `dout`=0xFFFF_FFD6, `vout`=0; signed DIV −7/2 -> 0xFFFF_FFFD; signed REM -> 0xFFFF_FFFF.
- Signed DIV 0x8000_0000 / 0xFFFF_FFFF -> `dout`=0x8000_0000, `vout`=1; DIV 5/0 -> `dout`=0xFFFF_FFFF, `dz`=1, `valid` in cycle 1; REM 5/0 -> 5.
- `abort` at cycle 10 of a DIV -> IDLE in cycle 11, no `valid`, `dout` unchanged. `start` while `busy`=1 -> ignored; operands changing mid-run do not alter the result.
- Back-to-back: `start` asserted in each DONE cycle -> `valid` every 34 cycles. `rstb` low mid-RUN -> all outputs 0 immediately.
- WIDTH=8, random signed/unsigned sweep of all four ops against a reference model -> exact match, `valid` in cycle 10.
